// File: rtl/tb_uart_if.sv
// Serial-pair bundle between the bench sequencer (master) and the 8N1 UART endpoint (slave).
interface tb_uart_if;
    logic       ser_rx;
    logic       ser_tx;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    modport master (
        output ser_rx, tx_start, tx_data,
        input  ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err
    );

    modport slave (
        input  ser_rx, tx_start, tx_data,
        output ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err
    );
endinterface

// File: rtl/tb_uart.sv
// 8N1 UART endpoint: level-handshake transmitter and strobe-output receiver,
// fully independent, each a two-process FSM with registered outputs.
module tb_uart #(
    parameter int unsigned BAUD_DIV = 347
) (
    input logic     clock,
    input logic     reset,
    tb_uart_if.slave bus
);
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shreg, tx_shreg_nxt;
    logic          ser_tx_q, ser_tx_nxt;
    logic          tx_busy_q, tx_busy_nxt;
    logic          tx_clear_q, tx_clear_nxt;

    logic          rx_s1, rx_s2, rx_prev;
    logic [1:0]    rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shreg, rx_shreg_nxt;
    logic [7:0]    rx_data_q, rx_data_nxt;
    logic          rx_valid_q, rx_valid_nxt;
    logic          rx_err_q, rx_err_nxt;

    assign bus.ser_tx       = ser_tx_q;
    assign bus.tx_busy      = tx_busy_q;
    assign bus.tx_clear_req = tx_clear_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_frame_err = rx_err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state   <= S_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shreg   <= '0;
            ser_tx_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_clear_q <= 1'b0;
        end else begin
            tx_state   <= tx_state_nxt;
            tx_cnt     <= tx_cnt_nxt;
            tx_bit     <= tx_bit_nxt;
            tx_shreg   <= tx_shreg_nxt;
            ser_tx_q   <= ser_tx_nxt;
            tx_busy_q  <= tx_busy_nxt;
            tx_clear_q <= tx_clear_nxt;
        end
    end

    // TX next state; ser_tx_nxt always carries the bit for the upcoming cycle
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + CW'(1);
        tx_bit_nxt   = tx_bit;
        tx_shreg_nxt = tx_shreg;
        ser_tx_nxt   = ser_tx_q;
        tx_busy_nxt  = tx_busy_q;
        tx_clear_nxt = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_nxt  = '0;
                ser_tx_nxt  = 1'b1;
                tx_busy_nxt = 1'b0;
                if (bus.tx_start) begin
                    tx_shreg_nxt = bus.tx_data;
                    tx_state_nxt = S_START;
                    ser_tx_nxt   = 1'b0;
                    tx_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = S_DATA;
                    ser_tx_nxt   = tx_shreg[0];
                end
            end
            S_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = S_STOP;
                        ser_tx_nxt   = 1'b1;
                    end else begin
                        tx_bit_nxt   = tx_bit + 3'd1;
                        tx_shreg_nxt = {1'b0, tx_shreg[7:1]};
                        ser_tx_nxt   = tx_shreg[1];
                    end
                end
            end
            default: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = S_IDLE;
                    ser_tx_nxt   = 1'b1;
                    tx_busy_nxt  = 1'b0;
                    tx_clear_nxt = 1'b1;
                end
            end
        endcase
    end

    // rx_prev lags the synchronized line by one cycle for 1->0 detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.ser_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shreg   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bit     <= rx_bit_nxt;
            rx_shreg   <= rx_shreg_nxt;
            rx_data_q  <= rx_data_nxt;
            rx_valid_q <= rx_valid_nxt;
            rx_err_q   <= rx_err_nxt;
        end
    end

    // RX next state: half-bit start check, then full-bit sampling
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + CW'(1);
        rx_bit_nxt   = rx_bit;
        rx_shreg_nxt = rx_shreg;
        rx_data_nxt  = rx_data_q;
        rx_valid_nxt = 1'b0;
        rx_err_nxt   = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_prev && !rx_s2) rx_state_nxt = S_START;
            end
            S_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shreg_nxt = {rx_s2, rx_shreg[7:1]};
                    if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end
            end
            default: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = S_IDLE;
                    if (rx_s2) begin
                        rx_data_nxt  = rx_shreg;
                        rx_valid_nxt = 1'b1;
                    end else begin
                        rx_err_nxt = 1'b1;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_tb_uart.sv
// Self-checking bench for tb_uart: TX bit timing, back-to-back handshake,
// loopback receive, framing error, glitch rejection and mid-frame reset.
module tb_tb_uart;
    localparam int B = 8;

    logic clock;
    logic reset;
    logic rx_drv;
    logic loopback;

    int vectors    = 0;
    int miscompares = 0;
    int n_valid;
    int n_err;
    logic [7:0] last_rx;

    logic       tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    tb_uart_if bus ();

    tb_uart #(.BAUD_DIV(B)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.ser_rx = loopback ? bus.ser_tx : rx_drv;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Drive one 10-bit frame (bit 0 first) then idle, counting strobes.
    task automatic drive_rx_bits(input logic [9:0] frame);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < B; j++) begin
                rx_drv = frame[k];
                @(negedge clock);
                if (bus.rx_valid) begin n_valid++; last_rx = bus.rx_data; end
                if (bus.rx_frame_err) n_err++;
            end
        end
        rx_drv = 1'b1;
        for (int j = 0; j < 3 * B; j++) begin
            @(negedge clock);
            if (bus.rx_valid) begin n_valid++; last_rx = bus.rx_data; end
            if (bus.rx_frame_err) n_err++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.tx_start = 1'b0; bus.tx_data = 8'h00;
        rx_drv = 1'b1; loopback = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors++; if (bus.ser_tx !== 1'b1) begin miscompares++; $display("FAIL reset_ser_tx: got %b want 1", bus.ser_tx); end
        vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy: got %b want 0", bus.tx_busy); end
        vectors++; if (bus.tx_clear_req !== 1'b0) begin miscompares++; $display("FAIL reset_clear_req: got %b want 0", bus.tx_clear_req); end
        vectors++; if (bus.rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        vectors++; if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        vectors++; if (bus.rx_frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_rx_frame_err: got %b want 0", bus.rx_frame_err); end
    endtask

    task automatic test_tx_single();
        logic       eb;
        logic [7:0] d;
        d = 8'hA5;
        @(negedge clock);
        bus.tx_data = d; bus.tx_start = 1'b1;
        tx_exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_exp_q.push_back(d[i]);
        tx_exp_q.push_back(1'b1);
        @(negedge clock);
        bus.tx_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            eb = tx_exp_q.pop_front();
            for (int j = 0; j < B; j++) begin
                vectors++; if (bus.ser_tx !== eb) begin miscompares++; $display("FAIL tx_bit%0d_cyc%0d: got %b want %b", k, j, bus.ser_tx, eb); end
                vectors++; if (bus.tx_busy !== 1'b1 || bus.tx_clear_req !== 1'b0) begin miscompares++; $display("FAIL tx_busy_window bit%0d: busy %b clear %b want 1 0", k, bus.tx_busy, bus.tx_clear_req); end
                @(negedge clock);
            end
        end
        vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL tx_busy_fall: got %b want 0", bus.tx_busy); end
        vectors++; if (bus.tx_clear_req !== 1'b1) begin miscompares++; $display("FAIL tx_clear_pulse: got %b want 1", bus.tx_clear_req); end
        @(negedge clock);
        vectors++; if (bus.tx_clear_req !== 1'b0 || bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL tx_after_frame: clear %b busy %b want 0 0", bus.tx_clear_req, bus.tx_busy); end
    endtask

    task automatic test_back_to_back();
        logic eb;
        @(negedge clock);
        bus.tx_data = 8'h00; bus.tx_start = 1'b1;
        @(negedge clock);
        for (int f = 0; f < 3; f++) begin
            tx_exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) tx_exp_q.push_back(i == 0 ? f[0] : (i == 1 ? f[1] : 1'b0));
            tx_exp_q.push_back(1'b1);
            for (int k = 0; k < 10; k++) begin
                eb = tx_exp_q.pop_front();
                for (int j = 0; j < B; j++) begin
                    if (j == B / 2) begin
                        vectors++; if (bus.ser_tx !== eb) begin miscompares++; $display("FAIL b2b_f%0d_bit%0d: got %b want %b", f, k, bus.ser_tx, eb); end
                    end
                    vectors++; if (bus.tx_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_f%0d_bit%0d: got %b want 1", f, k, bus.tx_busy); end
                    @(negedge clock);
                end
            end
            vectors++; if (bus.tx_busy !== 1'b0 || bus.tx_clear_req !== 1'b1) begin miscompares++; $display("FAIL b2b_gap_f%0d: busy %b clear %b want 0 1", f, bus.tx_busy, bus.tx_clear_req); end
            if (f < 2) bus.tx_data = 8'(f + 1);
            else       bus.tx_start = 1'b0;
            @(negedge clock);
            if (f < 2) begin
                vectors++; if (bus.tx_busy !== 1'b1 || bus.ser_tx !== 1'b0) begin miscompares++; $display("FAIL b2b_restart_f%0d: busy %b ser_tx %b want 1 0", f, bus.tx_busy, bus.ser_tx); end
            end else begin
                vectors++; if (bus.tx_busy !== 1'b0 || bus.ser_tx !== 1'b1) begin miscompares++; $display("FAIL b2b_stop: busy %b ser_tx %b want 0 1", bus.tx_busy, bus.ser_tx); end
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp;
        loopback = 1'b1;
        n_valid = 0; n_err = 0;
        @(negedge clock);
        bus.tx_data = 8'h3C; bus.tx_start = 1'b1;
        rx_exp_q.push_back(8'h3C);
        @(negedge clock);
        bus.tx_start = 1'b0;
        for (int c = 0; c < 12 * B + 20; c++) begin
            if (bus.rx_valid) begin
                n_valid++;
                vectors++;
                if (rx_exp_q.size() == 0) begin
                    miscompares++; $display("FAIL loop_unexpected_valid: got %h want none", bus.rx_data);
                end else begin
                    exp = rx_exp_q.pop_front();
                    if (bus.rx_data !== exp) begin miscompares++; $display("FAIL loop_rx_data: got %h want %h", bus.rx_data, exp); end
                end
            end
            if (bus.rx_frame_err) n_err++;
            @(negedge clock);
        end
        vectors++; if (n_valid != 1) begin miscompares++; $display("FAIL loop_valid_count: got %0d want 1", n_valid); end
        vectors++; if (n_err != 0) begin miscompares++; $display("FAIL loop_err_count: got %0d want 0", n_err); end
        loopback = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_frame_error();
        n_valid = 0; n_err = 0;
        drive_rx_bits({1'b0, 8'hFF, 1'b0});
        vectors++; if (n_err != 1) begin miscompares++; $display("FAIL ferr_err_count: got %0d want 1", n_err); end
        vectors++; if (n_valid != 0) begin miscompares++; $display("FAIL ferr_valid_count: got %0d want 0", n_valid); end
        vectors++; if (bus.rx_data !== 8'h3C) begin miscompares++; $display("FAIL ferr_rx_data_held: got %h want 3c", bus.rx_data); end
    endtask

    task automatic test_glitch();
        logic [7:0] exp;
        n_valid = 0; n_err = 0;
        rx_drv = 1'b0;
        repeat (2) @(negedge clock);
        rx_drv = 1'b1;
        for (int c = 0; c < 4 * B; c++) begin
            @(negedge clock);
            if (bus.rx_valid) n_valid++;
            if (bus.rx_frame_err) n_err++;
        end
        vectors++; if (n_valid != 0 || n_err != 0) begin miscompares++; $display("FAIL glitch_strobes: valid %0d err %0d want 0 0", n_valid, n_err); end
        rx_exp_q.push_back(8'h5A);
        drive_rx_bits({1'b1, 8'h5A, 1'b0});
        exp = rx_exp_q.pop_front();
        vectors++; if (n_valid != 1 || n_err != 0) begin miscompares++; $display("FAIL glitch_recover_strobes: valid %0d err %0d want 1 0", n_valid, n_err); end
        vectors++; if (last_rx !== exp) begin miscompares++; $display("FAIL glitch_recover_data: got %h want %h", last_rx, exp); end
    endtask

    task automatic test_reset_mid_tx();
        int n_clear;
        int n_busy;
        n_clear = 0; n_busy = 0;
        @(negedge clock);
        bus.tx_data = 8'h81; bus.tx_start = 1'b1;
        @(negedge clock);
        bus.tx_start = 1'b0;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++; if (bus.ser_tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ser_tx: got %b want 1", bus.ser_tx); end
        vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", bus.tx_busy); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 12 * B; c++) begin
            @(negedge clock);
            if (bus.tx_clear_req) n_clear++;
            if (bus.tx_busy) n_busy++;
        end
        vectors++; if (n_clear != 0) begin miscompares++; $display("FAIL rst_mid_clear_req: got %0d pulses want 0", n_clear); end
        vectors++; if (n_busy != 0) begin miscompares++; $display("FAIL rst_mid_busy_after: got %0d busy cycles want 0", n_busy); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_loopback();
        test_frame_error();
        test_glitch();
        test_reset_mid_tx();
        vectors++; if (rx_exp_q.size() != 0 || tx_exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: rx %0d tx %0d entries left want 0 0", rx_exp_q.size(), tx_exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
